// File: rtl/audio_out_sequencer_if.sv
// rtl/audio_out_sequencer_if.sv - mixer push port and controller DAC write port
interface audio_out_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              mix_valid;
    logic [DATA_W-1:0] mix_data;
    logic              mix_ready;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [DATA_W-1:0] left_channel_audio_out;
    logic [DATA_W-1:0] right_channel_audio_out;

    // Environment side: mixer source plus audio controller sink
    modport master (
        output mix_valid,
        output mix_data,
        output audio_out_allowed,
        input  mix_ready,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );

    // Sequencer side
    modport slave (
        input  mix_valid,
        input  mix_data,
        input  audio_out_allowed,
        output mix_ready,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );
endinterface

// File: rtl/audio_out_sequencer.sv
// rtl/audio_out_sequencer.sv - buffers mixer samples and strobes them into the DAC write port
module audio_out_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mute,
    audio_out_sequencer_if.slave  bus,
    output logic [ADDR_W:0]       fifo_level,
    output logic [15:0]           underrun_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] sample_q;
    logic              write_q;
    logic              arm_q;
    logic [15:0]       underrun_q;

    logic fifo_full, fifo_empty;
    logic push, pop, flush, underrun_event;

    // Extra pointer bit distinguishes full from empty
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);

    assign bus.mix_ready = enable & ~fifo_full;
    assign push          = bus.mix_valid & bus.mix_ready;

    assign bus.write_audio_out         = write_q;
    assign bus.left_channel_audio_out  = sample_q;
    assign bus.right_channel_audio_out = sample_q;
    assign underrun_count              = underrun_q;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state, pop, flush and starvation detection
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        flush          = 1'b0;
        underrun_event = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
                else        flush   = 1'b1;
            end
            S_WAIT: begin
                if (!enable) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.audio_out_allowed) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_WRITE;
                    end else if (arm_q) begin
                        underrun_event = 1'b1;
                    end
                end
            end
            // The strobe always completes, even if enable or allowed drops
            S_WRITE: state_d = S_GAP;
            // One idle cycle lets the controller's allowed flag catch up
            S_GAP: begin
                if (enable) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers; flush only happens while enable is low, so it never races a push
    always_ff @(posedge CLOCK_50) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage, no reset needed since the pointers gate every read
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.mix_data;
    end

    // Output sample, loaded only on WAIT to WRITE; mute zeroes data but still consumes
    always_ff @(posedge CLOCK_50) begin
        if (reset)    sample_q <= '0;
        else if (pop) sample_q <= mute ? '0 : mem[rd_ptr_q[ADDR_W-1:0]];
    end

    // Registered write strobe, high exactly while in WRITE
    always_ff @(posedge CLOCK_50) begin
        if (reset) write_q <= 1'b0;
        else       write_q <= (state_d == S_WRITE);
    end

    // Arm flag: one underrun per starvation episode, re-armed by each write
    always_ff @(posedge CLOCK_50) begin
        if (reset)                     arm_q <= 1'b1;
        else if (underrun_event)       arm_q <= 1'b0;
        else if (state_q == S_WRITE)   arm_q <= 1'b1;
    end

    // Saturating underrun counter, cleared only by reset
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            underrun_q <= '0;
        else if (underrun_event && (underrun_q != 16'hFFFF))
            underrun_q <= underrun_q + 16'd1;
    end
endmodule

// File: doc/audio_out_sequencer.md
Name: audio_out_sequencer

Overview:
Sequences mixer output samples into the audio controller's DAC write port.
- Accepts samples from the mixer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one-cycle write_audio_out strobes only while the controller reports audio_out_allowed.
- Applies mute and counts underrun events.
- Sits between the mixer and the audio controller instance in the audio top level.

Parameters:
DATA_W, 32, sample width; same word drives the left and right channels
ADDR_W, 2, FIFO address width; depth = 2**ADDR_W = 4 entries

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run; 0 = flush the FIFO and stop writing
mute  in  1  1 = write zero samples instead of FIFO data
mix_valid  in  1  mixer sample valid
mix_data  in  DATA_W  mixer sample
mix_ready  out  1  sequencer can accept a sample
audio_out_allowed  in  1  controller output FIFO has space
write_audio_out  out  1  one-cycle write strobe to the controller
left_channel_audio_out  out  DATA_W  sample to the controller, left channel
right_channel_audio_out  out  DATA_W  sample to the controller, right channel (identical to left)
fifo_level  out  ADDR_W+1  entries currently buffered, 0..4
underrun_count  out  16  saturating count of starvation events

Behaviour:
- Reset values: every output is 0. FIFO pointers = 0, state = IDLE, underrun arm flag = 1.
- Push handshake:
  - mix_ready = enable & (fifo_level != 4), combinational.
  - A push occurs on a clock edge where mix_valid & mix_ready.
  - A push is never possible while full. A push and a pop in the same cycle are legal when not full; fifo_level is then unchanged.
- Pointers wrap modulo 4. fifo_level = write count minus read count, ADDR_W+1 bits.
- FSM states: IDLE, WAIT, WRITE, GAP.
  - IDLE: write_audio_out = 0. If enable = 1, go to WAIT.
  - WAIT, when enable & audio_out_allowed & (fifo_level != 0):
    - Pop the head.
    - Load left/right outputs with mute ? 0 : head.
    - Go to WRITE.
  - WRITE: write_audio_out = 1 for exactly this one cycle; outputs stable. Go to GAP.
  - GAP: write_audio_out = 0 for one cycle, which covers the controller's one-cycle allowed update latency. Then go to WAIT, or to IDLE if enable = 0.
- Throughput: at most 1 sample per 3 clocks.
- Latency: sample pushed into an empty FIFO at edge N with allowed = 1 gives write_audio_out high during cycle N+2.
- write_audio_out is registered and high only in WRITE.
- left/right outputs change only on the WAIT→WRITE transition and otherwise hold the last written sample.
- enable deasserted:
  - In IDLE or WAIT: FIFO flushed (pointers cleared) on the next edge and state goes to IDLE.
  - In WRITE: the strobe completes, then GAP, then IDLE with flush.
  - mix_ready drops immediately, combinationally.
- Underrun counting:
  - Event = cycle in WAIT with enable & audio_out_allowed & fifo_level == 0 while the arm flag is 1.
  - On an event: increment underrun_count (saturates at 16'hFFFF, no wrap) and clear the arm flag.
  - The arm flag is set again on each WRITE.
- mute affects data only. Samples are still consumed and strobed at the normal rate.
- audio_out_allowed dropping during WRITE/GAP does not abort the strobe already issued. It is rechecked in WAIT.
- Reset mid-operation: everything returns to reset values on that edge. A write strobe in flight is cut, and buffered samples are discarded.
- The underrun counter clears only on reset, not on enable toggling.

Test Plan:
1. Basic write: reset, then enable = 1 and allowed = 1, push 32'h00001234. Required: write_audio_out high exactly one cycle, 2 cycles after the push; left = right = 32'h00001234 that cycle; fifo_level back to 0.
2. Fill and backpressure: allowed = 0, push 5 samples A..E. Required: first 4 accepted, mix_ready = 0 at fifo_level = 4, E held until space. Then set allowed = 1. Required: strobes every 3 cycles in order A, B, C, D, E.
3. Flow stall: allowed drops after 2 writes. Required: no strobe while allowed = 0, remaining samples retained. Allowed back to 1 → writes resume with no loss or duplication.
4. Mute: mute = 1, push 32'hFFFF0001. Required: strobe with left = right = 0, sample consumed.
5. Underrun: enable = 1, allowed = 1, FIFO empty for 100 cycles. Required: underrun_count = 1. After one write and empty again, underrun_count = 2. Force the counter to 16'hFFFF, trigger another event → stays at 16'hFFFF.
6. Disable/reset mid-stream: 3 samples buffered, drop enable in WAIT. Required: fifo_level = 0 next cycle, IDLE, no further strobes. Repeat with reset asserted during WRITE. Required: write_audio_out = 0 on the next cycle, all outputs 0.
